// File: rtl/psr_icc_unit.sv
// -----------------------------------------------------------------------------
// psr_icc_unit
//
// Processor State Register unit placed right after the ALU.
//  - Latches the ALU integer condition codes (N,Z,V,C) on cc-setting
//    instructions and feeds the stored carry back to the ALU as Cin.
//  - Evaluates Bicc branch conditions for the control unit, one cycle after
//    the request, using flags forwarded from the ALU when they are being
//    written in the same cycle.
//  - Tracks the current window pointer (CWP) against the WIM for SAVE and
//    RESTORE and raises window overflow / underflow traps, held until the
//    control unit acknowledges them.
//
// Ports
//  clk, rst           clock (rising edge), asynchronous active-high reset
//  icc_we, N/Z/V/C_in condition-code write strobe and ALU flags
//  br_eval, cond      branch evaluation request and Bicc cond field
//  save, restore      register-window requests
//  wim_we, wim_in     WIM write strobe and value
//  psr_we, psr_in     WRPSR strobe and value
//  trap_ack           control unit accepts the pending window trap
//  psr_out            PSR view: [23:20]=NZVC [7]=S [5]=ET [CWP_W-1:0]=CWP
//  cin_out            stored carry (no forwarding)
//  cwp                current window pointer
//  br_valid, br_taken branch result pulse and decision
//  win_trap           window trap pending
//  trap_type          01 = window overflow, 10 = window underflow, 00 = none
// -----------------------------------------------------------------------------
module psr_icc_unit #(
   parameter int NWINDOWS = 8,
   parameter int CWP_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                icc_we,
   input  logic                N_in,
   input  logic                Z_in,
   input  logic                V_in,
   input  logic                C_in,
   input  logic                br_eval,
   input  logic [3:0]          cond,
   input  logic                save,
   input  logic                restore,
   input  logic                wim_we,
   input  logic [NWINDOWS-1:0] wim_in,
   input  logic                psr_we,
   input  logic [31:0]         psr_in,
   input  logic                trap_ack,
   output logic [31:0]         psr_out,
   output logic                cin_out,
   output logic [CWP_W-1:0]    cwp,
   output logic                br_valid,
   output logic                br_taken,
   output logic                win_trap,
   output logic [1:0]          trap_type
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TRAP = 1'b1
   } state_t;

   localparam logic [1:0] TT_NONE      = 2'b00;
   localparam logic [1:0] TT_OVERFLOW  = 2'b01;
   localparam logic [1:0] TT_UNDERFLOW = 2'b10;

   localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);

   // ---------------------------------------------------------------------------
   // Window-pointer arithmetic (modulo NWINDOWS, which need not be a power of 2)
   // ---------------------------------------------------------------------------
   function automatic logic [CWP_W-1:0] cwp_dec(input logic [CWP_W-1:0] c);
      if (c == '0) return CWP_MAX;
      else         return c - 1'b1;
   endfunction

   function automatic logic [CWP_W-1:0] cwp_inc(input logic [CWP_W-1:0] c);
      if (c == CWP_MAX) return '0;
      else              return c + 1'b1;
   endfunction

   // CWP_W = clog2(NWINDOWS), so any CWP_W-bit value is below 2*NWINDOWS and a
   // single conditional subtraction is enough for the modulo.
   function automatic logic [CWP_W-1:0] cwp_mod(input logic [CWP_W-1:0] c);
      logic [CWP_W:0] wide;
      wide = {1'b0, c};
      if (wide >= (CWP_W+1)'(NWINDOWS)) return CWP_W'(wide - (CWP_W+1)'(NWINDOWS));
      else                              return c;
   endfunction

   // Bicc condition: cond[3] inverts the sense of the base test in cond[2:0].
   function automatic logic cond_eval(input logic [3:0] cd, input logic n,
                                      input logic z, input logic v, input logic c);
      logic base;
      case (cd[2:0])
         3'b000:  base = 1'b0;
         3'b001:  base = z;
         3'b010:  base = z | (n ^ v);
         3'b011:  base = n ^ v;
         3'b100:  base = c | z;
         3'b101:  base = c;
         3'b110:  base = n;
         default: base = v;
      endcase
      return base ^ cd[3];
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state;
   logic [3:0]          icc_q;      // {N,Z,V,C}
   logic                s_q;
   logic                et_q;
   logic [CWP_W-1:0]    cwp_q;
   logic [NWINDOWS-1:0] wim_q;
   logic                vld_p1;
   logic                taken_p1;
   logic                trap_q;
   logic [1:0]          ttype_q;

   // ---------------------------------------------------------------------------
   // Combinational decode (stage p0)
   // ---------------------------------------------------------------------------
   logic [3:0]       fwd_icc;
   logic             taken_p0;
   logic [CWP_W-1:0] nc_save;
   logic [CWP_W-1:0] nc_restore;
   logic             win_req;

   // Flags being written this cycle are used by a branch in the same cycle.
   assign fwd_icc    = icc_we ? {N_in, Z_in, V_in, C_in} : icc_q;
   assign taken_p0   = cond_eval(cond, fwd_icc[3], fwd_icc[2], fwd_icc[1], fwd_icc[0]);
   assign nc_save    = cwp_dec(cwp_q);
   assign nc_restore = cwp_inc(cwp_q);

   // A window request only acts when exactly one of save/restore is asserted,
   // traps are enabled, and no WRPSR overrides it.
   assign win_req    = (save ^ restore) && et_q && !psr_we;

   // ---------------------------------------------------------------------------
   // Registers (stage p1)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         icc_q    <= 4'b0000;
         s_q      <= 1'b1;
         et_q     <= 1'b1;
         cwp_q    <= '0;
         wim_q    <= NWINDOWS'(1) << (NWINDOWS - 1);
         vld_p1   <= 1'b0;
         taken_p1 <= 1'b0;
         trap_q   <= 1'b0;
         ttype_q  <= TT_NONE;
      end else begin
         // WIM update; window checks below still see the old value.
         if (wim_we) wim_q <= wim_in;

         vld_p1   <= br_eval;
         taken_p1 <= br_eval & taken_p0;

         if (psr_we) begin
            icc_q <= psr_in[23:20];
            s_q   <= psr_in[7];
            et_q  <= psr_in[5];
            cwp_q <= cwp_mod(psr_in[CWP_W-1:0]);
         end else if (icc_we) begin
            icc_q <= {N_in, Z_in, V_in, C_in};
         end

         case (state)
            ST_IDLE: begin
               if (win_req) begin
                  if (save) begin
                     if (wim_q[nc_save]) begin
                        state   <= ST_TRAP;
                        trap_q  <= 1'b1;
                        ttype_q <= TT_OVERFLOW;
                     end else begin
                        cwp_q <= nc_save;
                     end
                  end else begin
                     if (wim_q[nc_restore]) begin
                        state   <= ST_TRAP;
                        trap_q  <= 1'b1;
                        ttype_q <= TT_UNDERFLOW;
                     end else begin
                        cwp_q <= nc_restore;
                     end
                  end
               end
            end
            ST_TRAP: begin
               if (trap_ack) begin
                  state   <= ST_IDLE;
                  trap_q  <= 1'b0;
                  ttype_q <= TT_NONE;
                  // Trap entry moves to the handler's window with traps off;
                  // a simultaneous WRPSR keeps ownership of the PSR fields.
                  if (!psr_we) begin
                     et_q  <= 1'b0;
                     s_q   <= 1'b1;
                     cwp_q <= cwp_dec(cwp_q);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      psr_out              = 32'h0000_0000;
      psr_out[23:20]       = icc_q;
      psr_out[7]           = s_q;
      psr_out[5]           = et_q;
      psr_out[CWP_W-1:0]   = cwp_q;
   end

   assign cin_out   = icc_q[0];
   assign cwp       = cwp_q;
   assign br_valid  = vld_p1;
   assign br_taken  = taken_p1;
   assign win_trap  = trap_q;
   assign trap_type = ttype_q;

endmodule
